cdf_builder: RTL and testbench

Upstream stage of the histogram-equalization divider. After the histogram is complete, this block reads the 256-bin histogram memory and computes the running cumulative sum. It writes each CDF value into the CDF memory, records cdf_min (the first non-zero cumulative value), and checks that the total equals the image size. The divider stage consumes the CDF memory contents and cdf_min directly.

---
 rtl/cdf_builder_pkg.sv | 19 +
 rtl/cdf_builder_accum.sv | 67 ++++++
 rtl/cdf_builder.sv | 107 ++++++++++
 tb/tb_cdf_builder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cdf_builder_pkg.sv
// rtl/cdf_builder_pkg.sv - shared defaults and FSM encoding for the CDF builder
//
// Purpose: default sizing for the histogram/CDF memories and the 2-bit FSM
// state encoding, which the divider-side controller also uses for status muxing.
package cdf_builder_pkg;

  localparam int CDF_BINS   = 256;
  localparam int CDF_ADDR_W = 8;
  localparam int CDF_DATA_W = 32;
  localparam int CDF_SIZE   = 1600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cdf_state_e;

endpackage

// File: rtl/cdf_builder_accum.sv
// rtl/cdf_builder_accum.sv - running-sum accumulator, cdf_min capture and CDF write port
//
// Purpose: adds each returned histogram word into the running sum and emits
// the sum as a registered CDF memory write one cycle after the data arrives.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   clr                   clears sum, overflow and cdf_min state (accepted start)
//   in_valid, in_addr     delayed read strobe/address matching hist_data
//   hist_data             histogram word for in_addr
//   cdf_wr_en/addr/data   registered CDF memory write port
//   cdf_min, cdf_min_valid first non-zero cumulative value
//   acc, overflow         running sum and sticky carry-out flag
module cdf_accum
  import cdf_builder_pkg::*;
#(
  parameter int ADDR_W = CDF_ADDR_W,
  parameter int DATA_W = CDF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] hist_data,
  output logic              cdf_wr_en,
  output logic [ADDR_W-1:0] cdf_addr,
  output logic [DATA_W-1:0] cdf_data,
  output logic [DATA_W-1:0] cdf_min,
  output logic              cdf_min_valid,
  output logic [DATA_W-1:0] acc,
  output logic              overflow
);

  // One extra bit catches the carry out of the unsigned sum.
  logic [DATA_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, hist_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdf_wr_en     <= 1'b0;
      cdf_addr      <= '0;
      cdf_data      <= '0;
      cdf_min       <= '0;
      cdf_min_valid <= 1'b0;
      acc           <= '0;
      overflow      <= 1'b0;
    end else begin
      cdf_wr_en <= in_valid;
      if (clr) begin
        acc           <= '0;
        overflow      <= 1'b0;
        cdf_min       <= '0;
        cdf_min_valid <= 1'b0;
      end else if (in_valid) begin
        acc      <= sum[DATA_W-1:0];
        overflow <= overflow | sum[DATA_W];
        cdf_addr <= in_addr;
        cdf_data <= sum[DATA_W-1:0];
        if (!cdf_min_valid && (sum[DATA_W-1:0] != '0)) begin
          cdf_min       <= sum[DATA_W-1:0];
          cdf_min_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdf_builder.sv
// rtl/cdf_builder.sv - reads the histogram and writes its cumulative sum to CDF memory
//
// Purpose: sequences one read per cycle over all bins, feeds the returned data
// to cdf_accum, and checks the final total against the expected pixel count.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start                      build request, honoured only in IDLE
//   hist_rd_en/addr/data       histogram memory read port (1-cycle read latency)
//   cdf_wr_en/addr/data        CDF memory write port
//   cdf_min, cdf_min_valid     first non-zero CDF value
//   busy, done, total_err      status; total_err held until the next start
module cdf_builder
  import cdf_builder_pkg::*;
#(
  parameter int BINS   = CDF_BINS,
  parameter int ADDR_W = CDF_ADDR_W,
  parameter int DATA_W = CDF_DATA_W,
  parameter int SIZE   = CDF_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              hist_rd_en,
  output logic [ADDR_W-1:0] hist_addr,
  input  logic [DATA_W-1:0] hist_data,
  output logic              cdf_wr_en,
  output logic [ADDR_W-1:0] cdf_addr,
  output logic [DATA_W-1:0] cdf_data,
  output logic [DATA_W-1:0] cdf_min,
  output logic              cdf_min_valid,
  output logic              busy,
  output logic              done,
  output logic              total_err
);

  cdf_state_e        state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_v_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] acc;
  logic              overflow;
  logic              accept;
  logic              last_rd;
  logic              last_wr;

  assign accept  = (state == ST_IDLE) && start;
  assign last_rd = (rd_addr == ADDR_W'(BINS - 1));
  assign last_wr = cdf_wr_en && (cdf_addr == ADDR_W'(BINS - 1));

  assign hist_rd_en = (state == ST_READ);
  assign hist_addr  = rd_addr;
  assign busy       = (state == ST_READ) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      rd_v_d    <= 1'b0;
      rd_addr_d <= '0;
      total_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Delay the read strobe/address to line up with hist_data.
      rd_v_d <= hist_rd_en;
      if (hist_rd_en) rd_addr_d <= rd_addr;
      // The counter stops on the last bin so hist_addr holds it afterwards.
      if (accept) rd_addr <= '0;
      else if (hist_rd_en && !last_rd) rd_addr <= rd_addr + ADDR_W'(1);
      // The last write is on the bus in the final DRAIN cycle, so acc is final here.
      if (accept) total_err <= 1'b0;
      else if ((state == ST_DRAIN) && last_wr)
        total_err <= overflow || (acc != DATA_W'(SIZE));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (last_rd) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_wr) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  cdf_accum #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_accum (
    .clk          (clk),
    .reset        (reset),
    .clr          (accept),
    .in_valid     (rd_v_d),
    .in_addr      (rd_addr_d),
    .hist_data    (hist_data),
    .cdf_wr_en    (cdf_wr_en),
    .cdf_addr     (cdf_addr),
    .cdf_data     (cdf_data),
    .cdf_min      (cdf_min),
    .cdf_min_valid(cdf_min_valid),
    .acc          (acc),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_cdf_builder.sv
// tb/tb_cdf_builder.sv - directed table-driven bench for cdf_builder
module tb_cdf_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hist_rd_en;
  logic [7:0]  hist_addr;
  logic [31:0] hist_data = '0;
  logic        cdf_wr_en;
  logic [7:0]  cdf_addr;
  logic [31:0] cdf_data;
  logic [31:0] cdf_min;
  logic        cdf_min_valid;
  logic        busy;
  logic        done;
  logic        total_err;

  logic [31:0] hist_mem [256];
  logic [31:0] cdf_got  [256];

  int checks = 0;
  int failures = 0;
  int done_cyc, done_cnt, rd_cnt, wr_cnt, last_wr_cyc;

  cdf_builder dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .hist_rd_en   (hist_rd_en),
    .hist_addr    (hist_addr),
    .hist_data    (hist_data),
    .cdf_wr_en    (cdf_wr_en),
    .cdf_addr     (cdf_addr),
    .cdf_data     (cdf_data),
    .cdf_min      (cdf_min),
    .cdf_min_valid(cdf_min_valid),
    .busy         (busy),
    .done         (done),
    .total_err    (total_err)
  );

  always #5 clk = ~clk;

  // Histogram memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) if (hist_rd_en) hist_data <= hist_mem[hist_addr];

  typedef struct {
    int          pat;
    int          rep;
    logic [31:0] mn;
    logic        mv;
    logic        err;
    int          a0; logic [31:0] e0;
    int          a1; logic [31:0] e1;
    int          a2; logic [31:0] e2;
    int          a3; logic [31:0] e3;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hist_rd_en"}, 32'(hist_rd_en), 0);
    chk({tag, "_hist_addr"}, 32'(hist_addr), 0);
    chk({tag, "_cdf_wr_en"}, 32'(cdf_wr_en), 0);
    chk({tag, "_cdf_addr"}, 32'(cdf_addr), 0);
    chk({tag, "_cdf_data"}, cdf_data, 0);
    chk({tag, "_cdf_min"}, cdf_min, 0);
    chk({tag, "_cdf_min_valid"}, 32'(cdf_min_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_total_err"}, 32'(total_err), 0);
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) hist_mem[i] = '0;
    case (pat)
      0: for (int i = 10; i < 170; i++) hist_mem[i] = 32'd10;
      1: hist_mem[200] = 32'd1600;
      3: begin hist_mem[0] = 32'hFFFF_FFF0; hist_mem[1] = 32'h20; end
      4: hist_mem[0] = 32'd1600;
      default: ;
    endcase
  endtask

  // Full build: start sampled at edge 0, outputs sampled on each falling edge.
  task automatic run_build(input int rep);
    int cyc;
    done_cyc = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; last_wr_cyc = 0;
    for (int i = 0; i < 256; i++) cdf_got[i] = 32'hDEAD_BEEF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc <= 300) begin
      if (cyc == 1) begin
        chk("c1_busy", 32'(busy), 1);
        chk("c1_hist_addr", 32'(hist_addr), 0);
        chk("c1_total_err_clr", 32'(total_err), 0);
        chk("c1_min_valid_clr", 32'(cdf_min_valid), 0);
      end
      if (hist_rd_en) rd_cnt++;
      if (cdf_wr_en) begin
        wr_cnt++;
        cdf_got[cdf_addr] = cdf_data;
        if (cdf_addr == 8'd255) last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          chk("busy_at_done", 32'(busy), 0);
        end
      end
      start = (cyc == rep);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_cdf_all();
    logic [31:0] s;
    int bad;
    s = '0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      s = s + hist_mem[i];
      if (cdf_got[i] !== s) bad++;
    end
    chk("cdf_all_bad_count", 32'(bad), 0);
  endtask

  initial begin
    vecs[0] = '{pat:0, rep:0,  mn:32'd10,        mv:1'b1, err:1'b0,
                a0:9,  e0:32'd0,  a1:10,  e1:32'd10,   a2:169, e2:32'd1600, a3:255, e3:32'd1600};
    vecs[1] = '{pat:1, rep:0,  mn:32'd1600,      mv:1'b1, err:1'b0,
                a0:199, e0:32'd0, a1:200, e1:32'd1600, a2:255, e2:32'd1600, a3:0,   e3:32'd0};
    vecs[2] = '{pat:2, rep:0,  mn:32'd0,         mv:1'b0, err:1'b1,
                a0:0,  e0:32'd0,  a1:128, e1:32'd0,    a2:255, e2:32'd0,    a3:1,   e3:32'd0};
    vecs[3] = '{pat:3, rep:0,  mn:32'hFFFF_FFF0, mv:1'b1, err:1'b1,
                a0:0,  e0:32'hFFFF_FFF0, a1:1, e1:32'h10, a2:2, e2:32'h10, a3:255, e3:32'h10};
    vecs[4] = '{pat:4, rep:0,  mn:32'd1600,      mv:1'b1, err:1'b0,
                a0:0,  e0:32'd1600, a1:1, e1:32'd1600, a2:100, e2:32'd1600, a3:255, e3:32'd1600};
    vecs[5] = '{pat:0, rep:50, mn:32'd10,        mv:1'b1, err:1'b0,
                a0:9,  e0:32'd0,  a1:10,  e1:32'd10,   a2:169, e2:32'd1600, a3:255, e3:32'd1600};

    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      run_build(vecs[v].rep);
      chk("done_cycle", 32'(done_cyc), 259);
      chk("last_write_cycle", 32'(last_wr_cyc), 258);
      chk("read_count", 32'(rd_cnt), 256);
      chk("write_count", 32'(wr_cnt), 256);
      chk("done_pulses", 32'(done_cnt), 1);
      chk("cdf_min", cdf_min, vecs[v].mn);
      chk("cdf_min_valid", 32'(cdf_min_valid), 32'(vecs[v].mv));
      chk("total_err", 32'(total_err), 32'(vecs[v].err));
      chk("cdf_a0", cdf_got[vecs[v].a0], vecs[v].e0);
      chk("cdf_a1", cdf_got[vecs[v].a1], vecs[v].e1);
      chk("cdf_a2", cdf_got[vecs[v].a2], vecs[v].e2);
      chk("cdf_a3", cdf_got[vecs[v].a3], vecs[v].e3);
      chk("hist_addr_hold", 32'(hist_addr), 255);
      chk("cdf_addr_hold", 32'(cdf_addr), 255);
      chk("idle_after", 32'(busy), 0);
      check_cdf_all();
    end

    // Reset mid-build at cycle 100, then a fresh build.
    fill(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 100; c++) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    chk_zero("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rd_en", 32'(hist_rd_en), 0);
    fill(0);
    run_build(0);
    chk("rebuild_done_cycle", 32'(done_cyc), 259);
    chk("rebuild_cdf255", cdf_got[255], 32'd1600);
    chk("rebuild_cdf_min", cdf_min, 32'd10);
    chk("rebuild_total_err", 32'(total_err), 0);
    check_cdf_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
